pipe_mmio: RTL and testbench

Memory-mapped I/O peripheral for the pipelined CPU's memory stage. The MEM stage decodes I/O space from address bit 7 and drives this block with the word index, store data and store strobe, and it muxes this block's read data into the load path.

---
 rtl/pipe_mmio.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_mmio.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mmio.sv
// Memory-mapped I/O block for the CPU memory stage: debounced switches with
// edge latch, four-digit seven-segment display, and an auto-reload timer.
module pipe_mmio #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  input  logic [9:0]  io_in,
  output logic [27:0] io_out,
  output logic        irq
);

  localparam logic [4:0] ADDR_SW     = 5'd0;
  localparam logic [4:0] ADDR_DISP   = 5'd1;
  localparam logic [4:0] ADDR_BLANK  = 5'd2;
  localparam logic [4:0] ADDR_TCOUNT = 5'd3;
  localparam logic [4:0] ADDR_TCMP   = 5'd4;
  localparam logic [4:0] ADDR_TCTRL  = 5'd5;
  localparam logic [4:0] ADDR_SWEDGE = 5'd6;

  localparam logic [15:0] PRESCALE_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        wr_disp;
  logic        wr_blank;
  logic        wr_tcount;
  logic        wr_tcmp;
  logic        wr_tctrl;
  logic        wr_swedge;

  logic [9:0]  sync1;
  logic [9:0]  sync2;
  logic [15:0] prescale;
  logic        tick;
  logic [9:0]  sample;
  logic [9:0]  debounced;
  logic        deb_update;
  logic [9:0]  sw_rise;
  logic [9:0]  swedge;
  logic [9:0]  swedge_clr;

  logic [15:0] disp;
  logic [3:0]  blank;
  logic [27:0] seg_next;

  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        match;
  logic        en;
  logic        ie;
  logic        count_hit;
  logic        match_set;
  logic        match_clr;

  assign wr_disp   = we && (addr == ADDR_DISP);
  assign wr_blank  = we && (addr == ADDR_BLANK);
  assign wr_tcount = we && (addr == ADDR_TCOUNT);
  assign wr_tcmp   = we && (addr == ADDR_TCMP);
  assign wr_tctrl  = we && (addr == ADDR_TCTRL);
  assign wr_swedge = we && (addr == ADDR_SWEDGE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
    end
  end

  assign tick = (prescale == PRESCALE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 16'd1;
    end
  end

  // The debounced value only moves when two consecutive ticks saw the same word.
  assign deb_update = tick && (sync2 == sample);
  assign sw_rise    = deb_update ? (sync2 & ~debounced) : '0;
  assign swedge_clr = wr_swedge ? datain[9:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample    <= '0;
      debounced <= '0;
      swedge    <= '0;
    end else begin
      if (tick) begin
        sample <= sync2;
      end
      if (deb_update) begin
        debounced <= sync2;
      end
      swedge <= sw_rise | (swedge & ~swedge_clr);
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    seg_next = '1;
    for (int d = 0; d < 4; d++) begin
      seg_next[7*d +: 7] = blank[d] ? 7'b1111111 : hex_to_seg(disp[4*d +: 4]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp   <= '0;
      blank  <= 4'hF;
      io_out <= '1;
    end else begin
      if (wr_disp) begin
        disp <= datain[15:0];
      end
      if (wr_blank) begin
        blank <= datain[3:0];
      end
      io_out <= seg_next;
    end
  end

  // A software load of TCOUNT outranks both the reload and the increment.
  assign count_hit = (tcount == tcmp);
  assign match_set = en && count_hit && !wr_tcount;
  assign match_clr = wr_tctrl && datain[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= '1;
      match  <= 1'b0;
      en     <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (wr_tcount) begin
        tcount <= datain;
      end else if (en && count_hit) begin
        tcount <= '0;
      end else if (en) begin
        tcount <= tcount + 32'd1;
      end
      if (wr_tcmp) begin
        tcmp <= datain;
      end
      if (wr_tctrl) begin
        en <= datain[1];
        ie <= datain[2];
      end
      match <= match_set | (match & ~match_clr);
    end
  end

  assign irq = match & ie;

  always_comb begin
    dataout = '0;
    case (addr)
      ADDR_SW:     dataout = {22'b0, debounced};
      ADDR_DISP:   dataout = {16'b0, disp};
      ADDR_BLANK:  dataout = {28'b0, blank};
      ADDR_TCOUNT: dataout = tcount;
      ADDR_TCMP:   dataout = tcmp;
      ADDR_TCTRL:  dataout = {29'b0, ie, en, match};
      ADDR_SWEDGE: dataout = {22'b0, swedge};
      default:     dataout = '0;
    endcase
  end

endmodule

// File: tb/tb_pipe_mmio.sv
// Directed self-checking bench for pipe_mmio: display, debounce, timer,
// wrap/priority, unmapped accesses and asynchronous reset.
module tb_pipe_mmio;

  logic        clock;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic [9:0]  io_in;
  logic [27:0] io_out;
  logic        irq;

  int pass_count;
  int check_count;

  pipe_mmio #(.DEBOUNCE_CYCLES(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .io_in   (io_in),
    .io_out  (io_out),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(posedge clock);
    #1;
    we     = 1'b0;
    datain = '0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dataout;
  endtask

  task automatic test_display;
    logic [27:0] exp_seg;
    write_reg(5'd1, 32'h0000_08F0);
    write_reg(5'd2, 32'h0000_0000);
    check_count++;
    if (io_out !== 28'hFFFFFFF)
      $display("[TB] FAIL disp_latency io_out=%h expected=%h", io_out, 28'hFFFFFFF);
    else pass_count++;
    tick_clk(1);
    exp_seg = {7'b1000000, 7'b0000000, 7'b0001110, 7'b1000000};
    check_count++;
    if (io_out !== exp_seg)
      $display("[TB] FAIL disp_decode io_out=%h expected=%h", io_out, exp_seg);
    else pass_count++;
    write_reg(5'd2, 32'h0000_0004);
    tick_clk(1);
    exp_seg = {7'b1000000, 7'b1111111, 7'b0001110, 7'b1000000};
    check_count++;
    if (io_out !== exp_seg)
      $display("[TB] FAIL disp_blank io_out=%h expected=%h", io_out, exp_seg);
    else pass_count++;
  endtask

  task automatic test_debounce;
    logic [31:0] rd;
    bit found;
    io_in = 10'h008;
    tick_clk(3);
    io_in = 10'h000;
    tick_clk(12);
    read_reg(5'd0, rd);
    check_count++;
    if (rd !== 32'h0)
      $display("[TB] FAIL deb_glitch_sw read=%h expected=%h", rd, 32'h0);
    else pass_count++;
    read_reg(5'd6, rd);
    check_count++;
    if (rd !== 32'h0)
      $display("[TB] FAIL deb_glitch_edge read=%h expected=%h", rd, 32'h0);
    else pass_count++;
    io_in = 10'h008;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_clk(1);
      read_reg(5'd0, rd);
      if (rd == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    check_count++;
    if (!found)
      $display("[TB] FAIL deb_hold read=%h expected=%h within 10 clocks", rd, 32'h8);
    else pass_count++;
    read_reg(5'd6, rd);
    check_count++;
    if (rd !== 32'h8)
      $display("[TB] FAIL swedge_set read=%h expected=%h", rd, 32'h8);
    else pass_count++;
    write_reg(5'd6, 32'h8);
    read_reg(5'd6, rd);
    check_count++;
    if (rd !== 32'h0)
      $display("[TB] FAIL swedge_w1c read=%h expected=%h", rd, 32'h0);
    else pass_count++;
    read_reg(5'd0, rd);
    check_count++;
    if (rd !== 32'h8)
      $display("[TB] FAIL deb_stable read=%h expected=%h", rd, 32'h8);
    else pass_count++;
  endtask

  task automatic test_timer;
    logic [31:0] rd;
    write_reg(5'd4, 32'd5);
    write_reg(5'd3, 32'd0);
    write_reg(5'd5, 32'b110);
    tick_clk(5);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd5)
      $display("[TB] FAIL tmr_count5 read=%h expected=%h", rd, 32'd5);
    else pass_count++;
    read_reg(5'd5, rd);
    check_count++;
    if (rd !== 32'h6)
      $display("[TB] FAIL tmr_nomatch_yet read=%h expected=%h", rd, 32'h6);
    else pass_count++;
    tick_clk(1);
    read_reg(5'd5, rd);
    check_count++;
    if (rd !== 32'h7)
      $display("[TB] FAIL tmr_match read=%h expected=%h", rd, 32'h7);
    else pass_count++;
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd0)
      $display("[TB] FAIL tmr_reload read=%h expected=%h", rd, 32'd0);
    else pass_count++;
    check_count++;
    if (irq !== 1'b1)
      $display("[TB] FAIL tmr_irq_on irq=%b expected=1", irq);
    else pass_count++;
    write_reg(5'd5, 32'b111);
    check_count++;
    if (irq !== 1'b0)
      $display("[TB] FAIL tmr_w1c_irq irq=%b expected=0", irq);
    else pass_count++;
    tick_clk(3);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd4)
      $display("[TB] FAIL tmr_precollide read=%h expected=%h", rd, 32'd4);
    else pass_count++;
    tick_clk(1);
    write_reg(5'd5, 32'b111);
    read_reg(5'd5, rd);
    check_count++;
    if (rd !== 32'h7)
      $display("[TB] FAIL tmr_set_wins read=%h expected=%h", rd, 32'h7);
    else pass_count++;
    check_count++;
    if (irq !== 1'b1)
      $display("[TB] FAIL tmr_set_wins_irq irq=%b expected=1", irq);
    else pass_count++;
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    write_reg(5'd5, 32'b001);
    write_reg(5'd4, 32'd0);
    write_reg(5'd3, 32'hFFFF_FFFF);
    write_reg(5'd5, 32'b010);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'hFFFF_FFFF)
      $display("[TB] FAIL wrap_frozen read=%h expected=%h", rd, 32'hFFFF_FFFF);
    else pass_count++;
    tick_clk(1);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd0)
      $display("[TB] FAIL wrap_count read=%h expected=%h", rd, 32'd0);
    else pass_count++;
    read_reg(5'd5, rd);
    check_count++;
    if (rd !== 32'h2)
      $display("[TB] FAIL wrap_nomatch read=%h expected=%h", rd, 32'h2);
    else pass_count++;
    tick_clk(1);
    read_reg(5'd5, rd);
    check_count++;
    if (rd !== 32'h3)
      $display("[TB] FAIL wrap_match read=%h expected=%h", rd, 32'h3);
    else pass_count++;
    write_reg(5'd3, 32'd7);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd7)
      $display("[TB] FAIL load_priority read=%h expected=%h", rd, 32'd7);
    else pass_count++;
    write_reg(5'd5, 32'b000);
    tick_clk(2);
    read_reg(5'd3, rd);
    check_count++;
    if (rd !== 32'd8)
      $display("[TB] FAIL en_freeze read=%h expected=%h", rd, 32'd8);
    else pass_count++;
  endtask

  task automatic test_unmapped;
    logic [31:0] rd;
    logic [4:0]  idx [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    logic [31:0] exp [5] = '{32'h08F0, 32'h4, 32'd8, 32'd0, 32'h1};
    write_reg(5'd9, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      read_reg(idx[i], rd);
      check_count++;
      if (rd !== exp[i])
        $display("[TB] FAIL unmapped_keep_idx%0d read=%h expected=%h", idx[i], rd, exp[i]);
      else pass_count++;
    end
    read_reg(5'd9, rd);
    check_count++;
    if (rd !== 32'h0)
      $display("[TB] FAIL unmapped_read read=%h expected=%h", rd, 32'h0);
    else pass_count++;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [4:0]  idx [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    logic [31:0] exp [7] = '{32'h0, 32'h0, 32'hF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    write_reg(5'd5, 32'b110);
    tick_clk(1);
    check_count++;
    if (irq !== 1'b1)
      $display("[TB] FAIL rst_pre_irq irq=%b expected=1", irq);
    else pass_count++;
    reset = 1'b1;
    #1;
    check_count++;
    if (io_out !== 28'hFFFFFFF)
      $display("[TB] FAIL rst_io_out io_out=%h expected=%h", io_out, 28'hFFFFFFF);
    else pass_count++;
    check_count++;
    if (irq !== 1'b0)
      $display("[TB] FAIL rst_irq irq=%b expected=0", irq);
    else pass_count++;
    for (int i = 0; i < 7; i++) begin
      read_reg(idx[i], rd);
      check_count++;
      if (rd !== exp[i])
        $display("[TB] FAIL rst_idx%0d read=%h expected=%h", idx[i], rd, exp[i]);
      else pass_count++;
    end
    tick_clk(2);
    reset = 1'b0;
    tick_clk(2);
    read_reg(5'd0, rd);
    check_count++;
    if (rd !== 32'h0)
      $display("[TB] FAIL rst_deb_restart read=%h expected=%h", rd, 32'h0);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = '0;
    datain = '0;
    io_in  = '0;
    tick_clk(3);
    reset = 1'b0;
    tick_clk(1);
    check_count++;
    if (io_out !== 28'hFFFFFFF)
      $display("[TB] FAIL init_io_out io_out=%h expected=%h", io_out, 28'hFFFFFFF);
    else pass_count++;
    test_display();
    test_debounce();
    test_timer();
    test_wrap();
    test_unmapped();
    test_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
